// File: rtl/fifo_stream_reader_if.sv
// Bus bundle for fifo_stream_reader: FIFO read port plus the outgoing valid/ready stream.
// master = the reader, slave = the FIFO/consumer side.
interface fifo_stream_reader_if #(
    parameter int DW = 32
);
    logic          fifo_read;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        output fifo_read,
        input  fifo_rdata,
        input  fifo_empty,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  fifo_read,
        output fifo_rdata,
        output fifo_empty,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a programmed number of FIFO words onto a valid/ready stream through a 2-entry buffer.
// Defining FIFO_RD_TIMEOUT_EN adds a stall timeout that raises a sticky err and ends the transfer.
module fifo_stream_reader #(
    parameter int DW          = 32,
    parameter int LENW        = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [LENW-1:0]      len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    fifo_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [LENW-1:0] issue_rem;
    logic [LENW-1:0] send_rem;
    logic            inflight;
    logic [1:0]      buf_cnt;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [DW-1:0]   buf_q [2];
    logic            rd_en;
    logic            pop;
    logic            accept;
    logic            timeout;
    logic            m_valid;
    logic [2:0]      occ;

    assign m_valid = (buf_cnt != 2'd0);
    assign pop     = m_valid && bus.m_ready;
    assign accept  = (state == IDLE) && start;
    // Words that will sit in the buffer after this edge if no new read is issued
    assign occ     = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len != '0) ? RUN : DONE;
            RUN:     if ((pop && (send_rem == LENW'(1))) || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        rd_en = (state == RUN) && !bus.fifo_empty && (issue_rem != '0) && (occ < 3'd2);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            issue_rem <= '0;
            send_rem  <= '0;
            inflight  <= 1'b0;
            buf_cnt   <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
        end else if (timeout) begin
            // Abandon the transfer: buffered and in-flight words are dropped
            issue_rem <= '0;
            send_rem  <= '0;
            inflight  <= 1'b0;
            buf_cnt   <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (accept) begin
                issue_rem <= len;
                send_rem  <= len;
            end else begin
                if (rd_en) issue_rem <= issue_rem - LENW'(1);
                if (pop)   send_rem  <= send_rem - LENW'(1);
            end
            if (inflight) begin
                buf_q[wr_ptr] <= bus.fifo_rdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({inflight, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC) + 1;
    logic [SW-1:0] stall_cnt;

    assign timeout = (state == RUN) && !rd_en && !pop && (stall_cnt == SW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if ((state != RUN) || rd_en || pop) stall_cnt <= '0;
            else                                stall_cnt <= stall_cnt + SW'(1);
            if (accept)       err <= 1'b0;
            else if (timeout) err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign bus.fifo_read = rd_en;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = buf_q[rd_ptr];
    assign bus.m_last    = m_valid && (send_rem == LENW'(1));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model with garbage read data, stream recorder,
// and scenario tasks comparing against the expected word order, counts and timing.
module tb_fifo_stream_reader;
    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;

    fifo_stream_reader_if #(.DW(32)) bus();

    fifo_stream_reader #(.DW(32), .LENW(16), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .nrst(nrst), .start(start), .len(len),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks;
    int n_fail;
    int ready_mode;
    int st_cyc;

    logic [31:0] fifo_q[$];
    logic [31:0] feed_q[$];
    logic [31:0] got_q[$];
    bit          last_q[$];
    bit          rd_s;

    int rd_cnt, rd_empty, pop_cnt, hold_viol, out_viol, busy_cnt, done_cnt;
    int first_rd_cyc, first_pop_cyc, last_pop_cyc, done_cyc;
    bit done_err, done_valid, prev_stall;
    logic [31:0] prev_data;

    // FIFO model: pops on the sampled read strobe, drives random garbage on non-read cycles
    initial begin
        bus.fifo_rdata = '0;
        bus.fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            rd_s = bus.fifo_read;
            @(posedge clk);
            #1;
            if (rd_s && fifo_q.size() != 0) bus.fifo_rdata = fifo_q.pop_front();
            else                            bus.fifo_rdata = $urandom;
            if (feed_q.size() != 0 && $urandom_range(0, 3) != 0) fifo_q.push_back(feed_q.pop_front());
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = (cyc % 3 == 0);
                default: bus.m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Stream and strobe recorder
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.fifo_read) begin
                rd_cnt++;
                if (bus.fifo_empty) rd_empty++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) hold_viol++;
            if (bus.m_valid && bus.m_ready) begin
                got_q.push_back(bus.m_data);
                last_q.push_back(bus.m_last);
                if (pop_cnt == 0) first_pop_cyc = cyc;
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (rd_cnt - pop_cnt > 2) out_viol++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc   = cyc;
                done_err   = err;
                done_valid = bus.m_valid;
            end
        end
    end

    task automatic clear_mon();
        rd_cnt = 0; rd_empty = 0; pop_cnt = 0; hold_viol = 0; out_viol = 0;
        busy_cnt = 0; done_cnt = 0; first_rd_cyc = -1; first_pop_cyc = -1;
        last_pop_cyc = -1; done_cyc = -1; done_err = 0; done_valid = 0;
        prev_stall = 0; prev_data = '0;
        got_q.delete(); last_q.delete();
    endtask

    task automatic do_start(input int n);
        start  = 1'b1;
        len    = 16'(n);
        st_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != 0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (bus.fifo_read !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_read: got %b, expected 0", bus.fifo_read); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b, expected 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== 32'h0) begin n_fail++; $display("FAIL rst_m_data: got %h, expected 0", bus.m_data); end
        n_checks++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %b, expected 0", bus.m_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, expected 0", err); end
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst: got busy=%b valid=%b, expected 0 0", busy, bus.m_valid); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon(); ready_mode = 0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'h100 + i);
        @(posedge clk); #1;
        do_start(4);
        wait_done(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done: got no done, expected done within 50 cycles"); end
        n_checks++; if (pop_cnt !== 4) begin n_fail++; $display("FAIL basic_pops: got %0d, expected 4", pop_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_q[i] !== 32'h100 + i) begin n_fail++; $display("FAIL basic_data[%0d]: got %h, expected %h", i, got_q[i], 32'h100 + i); end
            n_checks++; if (last_q[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b, expected %b", i, last_q[i], (i == 3)); end
        end
        n_checks++; if (rd_cnt !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d, expected 4", rd_cnt); end
        n_checks++; if (first_rd_cyc !== st_cyc + 1) begin n_fail++; $display("FAIL basic_first_read: got cycle %0d, expected %0d", first_rd_cyc, st_cyc + 1); end
        n_checks++; if (first_pop_cyc !== st_cyc + 3) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d, expected %0d", first_pop_cyc, st_cyc + 3); end
        n_checks++; if (last_pop_cyc !== first_pop_cyc + 3) begin n_fail++; $display("FAIL basic_full_rate: got last pop %0d, expected %0d", last_pop_cyc, first_pop_cyc + 3); end
        n_checks++; if (done_cyc !== last_pop_cyc + 1) begin n_fail++; $display("FAIL basic_done_time: got %0d, expected %0d", done_cyc, last_pop_cyc + 1); end
        n_checks++; if (busy_cnt !== done_cyc - st_cyc) begin n_fail++; $display("FAIL basic_busy_len: got %0d, expected %0d", busy_cnt, done_cyc - st_cyc); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] exp_q[$];
        clear_mon(); ready_mode = 1;
        for (int i = 0; i < 6; i++) begin exp_q.push_back($urandom); fifo_q.push_back(exp_q[i]); end
        @(posedge clk); #1;
        do_start(6);
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done: got no done, expected done within 100 cycles"); end
        n_checks++; if (pop_cnt !== 6) begin n_fail++; $display("FAIL bp_pops: got %0d, expected 6", pop_cnt); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (last_q[5] !== 1'b1 || last_q[4] !== 1'b0) begin n_fail++; $display("FAIL bp_last: got %b%b, expected 01", last_q[4], last_q[5]); end
        n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles, expected 0", hold_viol); end
        n_checks++; if (out_viol !== 0) begin n_fail++; $display("FAIL bp_outstanding: got %0d cycles over 2, expected 0", out_viol); end
        n_checks++; if (rd_cnt !== 6) begin n_fail++; $display("FAIL bp_reads: got %0d, expected 6", rd_cnt); end
        n_checks++; if (done_cyc !== last_pop_cyc + 1) begin n_fail++; $display("FAIL bp_done_time: got %0d, expected %0d", done_cyc, last_pop_cyc + 1); end
    endtask

    task automatic test_underflow();
        bit ok;
        clear_mon(); ready_mode = 0;
        fifo_q.push_back(32'hA0);
        @(posedge clk); #1;
        do_start(3);
        repeat (5) @(posedge clk);
        #1;
        fifo_q.push_back(32'hA1);
        fifo_q.push_back(32'hA2);
        wait_done(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL uf_done: got no done, expected done within 50 cycles"); end
        n_checks++; if (rd_empty !== 0) begin n_fail++; $display("FAIL uf_read_empty: got %0d reads while empty, expected 0", rd_empty); end
        n_checks++; if (rd_cnt !== 3) begin n_fail++; $display("FAIL uf_reads: got %0d, expected 3", rd_cnt); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got_q[i] !== 32'hA0 + i) begin n_fail++; $display("FAIL uf_data[%0d]: got %h, expected %h", i, got_q[i], 32'hA0 + i); end
            n_checks++; if (last_q[i] !== (i == 2)) begin n_fail++; $display("FAIL uf_last[%0d]: got %b, expected %b", i, last_q[i], (i == 2)); end
        end
    endtask

    task automatic test_zero_ignore();
        bit ok;
        clear_mon(); ready_mode = 0;
        do_start(0);
        wait_done(10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done: got no done, expected done"); end
        n_checks++; if (done_cyc !== st_cyc + 1) begin n_fail++; $display("FAIL zero_done_time: got %0d, expected %0d", done_cyc, st_cyc + 1); end
        n_checks++; if (busy_cnt !== 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles, expected 1", busy_cnt); end
        n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL zero_reads: got %0d, expected 0", rd_cnt); end
        clear_mon();
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hB0 + i);
        @(posedge clk); #1;
        do_start(3);
        start = 1'b1; len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, ok);
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d, expected 1", done_cnt); end
        n_checks++; if (pop_cnt !== 3) begin n_fail++; $display("FAIL ign_pops: got %0d, expected 3", pop_cnt); end
        n_checks++; if (rd_cnt !== 3) begin n_fail++; $display("FAIL ign_reads: got %0d, expected 3", rd_cnt); end
        n_checks++; if (fifo_q.size() !== 2) begin n_fail++; $display("FAIL ign_fifo_left: got %0d, expected 2", fifo_q.size()); end
        fifo_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int guard;
        clear_mon(); ready_mode = 0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h200 + i);
        @(posedge clk); #1;
        do_start(8);
        guard = 0;
        while (pop_cnt < 3 && guard < 50) begin @(posedge clk); #1; guard++; end
        n_checks++; if (pop_cnt !== 3) begin n_fail++; $display("FAIL rm_progress: got %0d pops, expected 3", pop_cnt); end
        #2 nrst = 1'b0;
        #1;
        n_checks++; if (bus.fifo_read !== 1'b0) begin n_fail++; $display("FAIL rm_fifo_read: got %b, expected 0", bus.fifo_read); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_m_valid: got %b, expected 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== 32'h0) begin n_fail++; $display("FAIL rm_m_data: got %h, expected 0", bus.m_data); end
        n_checks++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL rm_m_last: got %b, expected 0", bus.m_last); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rm_busy_done: got %b %b, expected 0 0", busy, done); end
        @(posedge clk); #1;
        fifo_q.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rm_no_done: got %0d done pulses, expected 0", done_cnt); end
        clear_mon();
        fifo_q.push_back(32'h300);
        fifo_q.push_back(32'h301);
        @(posedge clk); #1;
        do_start(2);
        wait_done(40, ok);
        n_checks++; if (!ok || pop_cnt !== 2) begin n_fail++; $display("FAIL rm_after: got done=%b pops=%0d, expected 1 2", ok, pop_cnt); end
        n_checks++; if (got_q[0] !== 32'h300 || got_q[1] !== 32'h301) begin n_fail++; $display("FAIL rm_after_data: got %h %h, expected 300 301", got_q[0], got_q[1]); end
        n_checks++; if (last_q[1] !== 1'b1 || rd_cnt !== 2) begin n_fail++; $display("FAIL rm_after_last: got last=%b reads=%0d, expected 1 2", last_q[1], rd_cnt); end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        logic [31:0] w;
        logic [31:0] exp_q[$];
        ready_mode = 2;
        for (int it = 0; it < 8; it++) begin
            clear_mon();
            exp_q.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n + 2; i++) begin w = $urandom; exp_q.push_back(w); feed_q.push_back(w); end
            do_start(n);
            wait_done(400, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_done: got no done, expected done within 400 cycles", it); end
            n_checks++; if (pop_cnt !== n) begin n_fail++; $display("FAIL rnd%0d_pops: got %0d, expected %0d", it, pop_cnt, n); end
            n_checks++; if (rd_cnt !== n) begin n_fail++; $display("FAIL rnd%0d_reads: got %0d, expected %0d", it, rd_cnt, n); end
            for (int i = 0; i < n; i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_data[%0d]: got %h, expected %h", it, i, got_q[i], exp_q[i]); end
                n_checks++; if (last_q[i] !== (i == n - 1)) begin n_fail++; $display("FAIL rnd%0d_last[%0d]: got %b, expected %b", it, i, last_q[i], (i == n - 1)); end
            end
            n_checks++; if (rd_empty !== 0 || hold_viol !== 0 || out_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_rules: got empty_rd=%0d hold=%0d outst=%0d, expected 0 0 0", it, rd_empty, hold_viol, out_viol); end
            n_checks++; if (done_cyc !== last_pop_cyc + 1) begin n_fail++; $display("FAIL rnd%0d_done_time: got %0d, expected %0d", it, done_cyc, last_pop_cyc + 1); end
            repeat (2) @(posedge clk);
            #1;
            feed_q.delete();
            fifo_q.delete();
        end
    endtask

`ifdef FIFO_RD_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_mon(); ready_mode = 0;
        fifo_q.delete();
        @(posedge clk); #1;
        do_start(4);
        wait_done(64, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL to_done: got no done, expected done within 64 cycles"); end
        n_checks++; if (done_cyc !== st_cyc + 17) begin n_fail++; $display("FAIL to_done_time: got %0d, expected %0d", done_cyc, st_cyc + 17); end
        n_checks++; if (done_err !== 1'b1 || done_valid !== 1'b0) begin n_fail++; $display("FAIL to_err_valid: got err=%b valid=%b, expected 1 0", done_err, done_valid); end
        n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL to_reads: got %0d, expected 0", rd_cnt); end
        @(posedge clk); #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b, expected 1", err); end
        clear_mon();
        fifo_q.push_back(32'h400);
        @(posedge clk); #1;
        do_start(1);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b, expected 0", err); end
        wait_done(40, ok);
        n_checks++; if (!ok || got_q[0] !== 32'h400) begin n_fail++; $display("FAIL to_recover: got done=%b data=%h, expected 1 400", ok, got_q[0]); end
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        clear_mon(); ready_mode = 0;
        fifo_q.delete();
        @(posedge clk); #1;
        do_start(2);
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (done_cnt !== 0 || busy !== 1'b1) begin n_fail++; $display("FAIL wait_stall: got done=%0d busy=%b, expected 0 1", done_cnt, busy); end
        n_checks++; if (rd_cnt !== 0 || err !== 1'b0) begin n_fail++; $display("FAIL wait_reads: got reads=%0d err=%b, expected 0 0", rd_cnt, err); end
        fifo_q.push_back(32'h500);
        fifo_q.push_back(32'h501);
        wait_done(40, ok);
        n_checks++; if (!ok || pop_cnt !== 2 || got_q[1] !== 32'h501) begin n_fail++; $display("FAIL wait_resume: got done=%b pops=%0d data=%h, expected 1 2 501", ok, pop_cnt, got_q[1]); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0; start = 1'b0; len = '0; ready_mode = 0;
        n_checks = 0; n_fail = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_underflow();
        test_zero_ignore();
        test_reset_mid();
        test_random();
`ifdef FIFO_RD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
